// File: rtl/audio_buf_pkg.sv
// Shared types for the audio record/playback buffer controller.
// State encoding doubles as the mode_in / state_out encoding.
package audio_buf_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECORD    = 2'd1,
        PLAY_ONCE = 2'd2,
        PLAY_LOOP = 2'd3
    } state_t;

    localparam logic [1:0] MODE_IDLE      = 2'd0;
    localparam logic [1:0] MODE_RECORD    = 2'd1;
    localparam logic [1:0] MODE_PLAY_ONCE = 2'd2;
    localparam logic [1:0] MODE_PLAY_LOOP = 2'd3;

endpackage

// File: rtl/rd_valid_pipe.sv
// Tracks reads in flight to the sample memory: one flag per cycle of read latency.
// The oldest flag is the capture strobe; any set flag means a read is pending.
module rd_valid_pipe #(
    parameter int unsigned LATENCY = 2
) (
    input  logic clk_in,
    input  logic flush_in,
    input  logic issue_in,
    output logic capture_out,
    output logic pending_out
);

    logic [LATENCY-1:0] stages;

    always_ff @(posedge clk_in) begin
        if (flush_in) begin
            stages <= '0;
        end else begin
            stages <= (stages << 1) | LATENCY'(issue_in);
        end
    end

    assign capture_out = stages[LATENCY-1];
    assign pending_out = |stages;

endmodule

// File: rtl/audio_buffer_ctrl.sv
// Record/playback controller: streams samples into an external BRAM and plays
// them back one per rate tick, with record, play-once and play-loop modes.
module audio_buffer_ctrl
    import audio_buf_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned CHANNELS     = 1,
    parameter int unsigned DEPTH        = 40000,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [1:0]                       mode_in,
    input  logic                             start_in,
    input  logic                             stop_in,
    input  logic [SAMPLE_WIDTH*CHANNELS-1:0] sample_in,
    input  logic                             sample_valid_in,
    input  logic                             tick_in,
    output logic [$clog2(DEPTH)-1:0]         mem_addr_out,
    output logic [SAMPLE_WIDTH*CHANNELS-1:0] mem_wdata_out,
    output logic                             mem_we_out,
    input  logic [SAMPLE_WIDTH*CHANNELS-1:0] mem_rdata_in,
    output logic [SAMPLE_WIDTH*CHANNELS-1:0] sample_out,
    output logic                             sample_valid_out,
    output logic [1:0]                       state_out,
    output logic [$clog2(DEPTH+1)-1:0]       len_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic                             overrun_out
);

    localparam int unsigned WW = SAMPLE_WIDTH * CHANNELS;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH + 1);

    state_t          state, state_nxt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   rd_ptr_inc;
    logic [AW-1:0]   mem_addr;
    logic [WW-1:0]   mem_wdata, sample_q;
    logic            mem_we, sample_valid, done, overrun;

    logic            start_go;
    logic            rec_write, rec_full;
    logic            rd_issue, rd_capture, rd_pending, pipe_capture;
    logic            play_end, done_nxt, overrun_nxt;

    // wr_ptr doubles as the recorded length: both clear on record start and advance together
    assign len_out          = wr_ptr;
    assign rd_ptr_inc       = rd_ptr + PW'(1);
    assign start_go         = (state == IDLE) && start_in && !stop_in && (mode_in != MODE_IDLE);

    rd_valid_pipe #(
        .LATENCY(READ_LATENCY)
    ) u_rd_valid_pipe (
        .clk_in     (clk_in),
        .flush_in   (rst_in || stop_in),
        .issue_in   (rd_issue),
        .capture_out(pipe_capture),
        .pending_out(rd_pending)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop_in) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (start_go) state_nxt = state_t'(mode_in);
                RECORD:    if (rec_full) state_nxt = IDLE;
                PLAY_ONCE: if (wr_ptr == '0 || play_end) state_nxt = IDLE;
                PLAY_LOOP: if (wr_ptr == '0) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rec_write   = 1'b0;
        rec_full    = 1'b0;
        rd_issue    = 1'b0;
        rd_capture  = 1'b0;
        play_end    = 1'b0;
        overrun_nxt = 1'b0;
        done_nxt    = 1'b0;
        if (!stop_in) begin
            case (state)
                RECORD: begin
                    rec_write = sample_valid_in;
                    rec_full  = sample_valid_in && (wr_ptr == PW'(DEPTH - 1));
                    done_nxt  = rec_full;
                end
                PLAY_ONCE, PLAY_LOOP: begin
                    rd_capture = pipe_capture;
                    if (tick_in) begin
                        if (rd_pending) begin
                            overrun_nxt = 1'b1;
                        end else if (wr_ptr != '0 && (state == PLAY_LOOP || rd_ptr < wr_ptr)) begin
                            rd_issue = 1'b1;
                        end
                    end
                    // rd_ptr sits at len only after the final read of a one-shot pass was issued
                    play_end = (state == PLAY_ONCE) && pipe_capture && (rd_ptr == wr_ptr);
                    done_nxt = (state == PLAY_ONCE) && (play_end || wr_ptr == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            sample_q     <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            mem_we       <= rec_write;
            sample_valid <= rd_capture;
            done         <= done_nxt;
            overrun      <= overrun_nxt;
            if (start_go) begin
                rd_ptr <= '0;
                if (mode_in == MODE_RECORD) wr_ptr <= '0;
            end
            if (rec_write) begin
                mem_addr  <= wr_ptr[AW-1:0];
                mem_wdata <= sample_in;
                wr_ptr    <= wr_ptr + PW'(1);
            end
            if (rd_issue) begin
                mem_addr <= rd_ptr[AW-1:0];
                rd_ptr   <= (state == PLAY_LOOP && rd_ptr_inc == wr_ptr) ? '0 : rd_ptr_inc;
            end
            if (rd_capture) begin
                sample_q <= mem_rdata_in;
            end
        end
    end

    assign mem_addr_out     = mem_addr;
    assign mem_wdata_out    = mem_wdata;
    assign mem_we_out       = mem_we;
    assign sample_out       = sample_q;
    assign sample_valid_out = sample_valid;
    assign state_out        = state;
    assign busy_out         = (state != IDLE);
    assign done_out         = done;
    assign overrun_out      = overrun;

endmodule
